// File: rtl/adc_ctrl_pkg.sv
// Shared definitions for the external parallel ADC front-end controller:
// FSM state encoding, default parameter values and data width.
package adc_ctrl_pkg;

    // Width of one ADC sample and of a FIFO write word.
    localparam int unsigned AdcDataW = 16;

    // Default parameter values for adc_sample_ctrl.
    localparam int unsigned DefNch     = 8;
    localparam int unsigned DefConvstW = 4;
    localparam int unsigned DefRdW     = 3;
    localparam int unsigned DefBusyTo  = 1023;

    // Smallest usable period; shorter requests are stretched to this.
    localparam logic [15:0] MinPeriod = 16'd2;

    // One-hot controller states.
    typedef enum logic [4:0] {
        StIdle  = 5'b00001,
        StConv  = 5'b00010,
        StWait  = 5'b00100,
        StRead  = 5'b01000,
        StRhigh = 5'b10000
    } state_e;

    // Period actually used by the period counter.
    function automatic logic [15:0] clamp_period(input logic [15:0] p);
        return (p < MinPeriod) ? MinPeriod : p;
    endfunction

endpackage

// File: rtl/sync2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
module sync2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/adc_sample_ctrl.sv
// Front-end controller for an external 16-bit parallel ADC. Starts a
// conversion every period, reads NCH channels over CS/RD and pushes each
// sample into the FIFO write port. Whole frames are dropped when the FIFO is
// almost full at frame start so the FIFO never holds a partial frame.
module adc_sample_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int unsigned NCH      = DefNch,
    parameter int unsigned CONVST_W = DefConvstW,
    parameter int unsigned RD_W     = DefRdW,
    parameter int unsigned BUSY_TO  = DefBusyTo
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [15:0]         period,
    input  logic                adc_busy,
    input  logic [AdcDataW-1:0] adc_db,
    input  logic                fifo_afull,
    output logic                adc_convst,
    output logic                adc_cs_n,
    output logic                adc_rd_n,
    output logic [AdcDataW-1:0] wrdata,
    output logic                wren,
    output logic                ovf,
    output logic                busy_err,
    output logic [7:0]          drop_cnt
);

    localparam int unsigned ChW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned WidMax = (CONVST_W > RD_W) ? CONVST_W : RD_W;
    localparam int unsigned WidW   = $clog2(WidMax + 1);
    localparam int unsigned WaitW  = $clog2(BUSY_TO + 1);

    localparam logic [WidW-1:0]  ConvLast = WidW'(CONVST_W - 1);
    localparam logic [WidW-1:0]  RdLast   = WidW'(RD_W - 1);
    localparam logic [ChW-1:0]   ChLast   = ChW'(NCH - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(BUSY_TO - 1);

    // Period counter
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] per_q, per_d;
    logic        tick;

    // Enable edge detect for clearing the status registers
    logic en_q;
    logic en_rise;

    // Synchronised ADC busy
    logic busy_s;

    // FSM and its counters
    state_e           state_q;
    logic [WidW-1:0]  wid_q;
    logic [WaitW-1:0] wait_q;
    logic [ChW-1:0]   ch_q;
    logic             seen_busy_q;
    logic             drop_q;

    sync2ff u_busy_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (adc_busy),
        .q_o    (busy_s)
    );

    // Period counter next state: wrap on tick, hold at zero while disabled and
    // keep tracking the requested period until the next wrap.
    always_comb begin
        tick  = enable && (cnt_q == (per_q - 16'd1));
        cnt_d = cnt_q;
        per_d = per_q;
        if (!enable) begin
            cnt_d = 16'd0;
            per_d = clamp_period(period);
        end else if (tick) begin
            cnt_d = 16'd0;
            per_d = clamp_period(period);
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Period counter and enable history registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 16'd0;
            per_q <= MinPeriod;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
            en_q  <= enable;
        end
    end

    assign en_rise = enable && !en_q;

    // Conversion/read sequencer with registered bus outputs and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            wid_q       <= '0;
            wait_q      <= '0;
            ch_q        <= '0;
            seen_busy_q <= 1'b0;
            drop_q      <= 1'b0;
            adc_convst  <= 1'b0;
            adc_cs_n    <= 1'b1;
            adc_rd_n    <= 1'b1;
            wrdata      <= '0;
            wren        <= 1'b0;
            ovf         <= 1'b0;
            busy_err    <= 1'b0;
            drop_cnt    <= 8'd0;
        end else begin
            wren <= 1'b0;

            if (en_rise) begin
                ovf      <= 1'b0;
                busy_err <= 1'b0;
                drop_cnt <= 8'd0;
            end

            // A tick while a frame is in flight is lost, not queued.
            if (tick && (state_q != StIdle)) begin
                ovf <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (tick) begin
                        state_q    <= StConv;
                        adc_convst <= 1'b1;
                        wid_q      <= '0;
                        // Drop decision is frozen for the whole frame.
                        drop_q     <= fifo_afull;
                        if (fifo_afull && (drop_cnt != 8'hFF)) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
                    end
                end

                StConv: begin
                    if (wid_q == ConvLast) begin
                        adc_convst  <= 1'b0;
                        state_q     <= StWait;
                        wait_q      <= '0;
                        seen_busy_q <= 1'b0;
                    end else begin
                        wid_q <= wid_q + 1'b1;
                    end
                end

                StWait: begin
                    wait_q <= wait_q + 1'b1;
                    if (busy_s) begin
                        seen_busy_q <= 1'b1;
                    end
                    if (seen_busy_q && !busy_s) begin
                        state_q  <= StRead;
                        adc_cs_n <= 1'b0;
                        adc_rd_n <= 1'b0;
                        wid_q    <= '0;
                    end else if (wait_q == WaitLast) begin
                        // Read anyway so the ADC channel pointer stays aligned.
                        busy_err <= 1'b1;
                        state_q  <= StRead;
                        adc_cs_n <= 1'b0;
                        adc_rd_n <= 1'b0;
                        wid_q    <= '0;
                    end
                end

                StRead: begin
                    if (wid_q == RdLast) begin
                        wrdata   <= adc_db;
                        adc_rd_n <= 1'b1;
                        wren     <= !drop_q;
                        state_q  <= StRhigh;
                    end else begin
                        wid_q <= wid_q + 1'b1;
                    end
                end

                StRhigh: begin
                    if (ch_q == ChLast) begin
                        ch_q     <= '0;
                        adc_cs_n <= 1'b1;
                        state_q  <= StIdle;
                    end else begin
                        ch_q     <= ch_q + 1'b1;
                        adc_rd_n <= 1'b0;
                        wid_q    <= '0;
                        state_q  <= StRead;
                    end
                end

                default: begin
                    state_q    <= StIdle;
                    adc_convst <= 1'b0;
                    adc_cs_n   <= 1'b1;
                    adc_rd_n   <= 1'b1;
                end
            endcase
        end
    end

endmodule
